// File: rtl/multiplier_4bit_carry.sv
// Registered 4x4 unsigned array multiplier with a carry addend.
// PRODUCT = A*B + carry_in; carry_out flags a result wider than 4 bits.
module multiplier_4bit_carry (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       carry_in,
  output logic [7:0] PRODUCT,
  output logic       carry_out
);

  logic [7:0] acc;
  logic [7:0] addend;
  logic [7:0] sum;
  logic       c;
  logic [7:0] product_d;
  logic       carry_out_d;

  // Row 0 is the bare partial product; rows 1..3 are ripple adders.
  // carry_in is the carry into bit 0 of the first adder row, so no incrementer.
  always_comb begin
    acc    = {4'b0000, A & {4{B[0]}}};
    addend = 8'h00;
    sum    = 8'h00;
    c      = 1'b0;
    for (int r = 1; r < 4; r++) begin
      addend = {4'b0000, A & {4{B[r]}}} << r;
      c      = (r == 1) ? carry_in : 1'b0;
      for (int b = 0; b < 8; b++) begin
        sum[b] = acc[b] ^ addend[b] ^ c;
        c      = (acc[b] & addend[b]) | (c & (acc[b] ^ addend[b]));
      end
      acc = sum;
    end
    product_d   = acc;
    carry_out_d = |acc[7:4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PRODUCT   <= 8'h00;
      carry_out <= 1'b0;
    end else begin
      PRODUCT   <= product_d;
      carry_out <= carry_out_d;
    end
  end

endmodule

// File: tb/tb_multiplier_4bit_carry.sv
// Scoreboard bench for multiplier_4bit_carry: driver pushes expectations,
// a forked monitor pops and compares two time units after each rising edge.
module tb_multiplier_4bit_carry;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic       carry_in;
  logic [7:0] PRODUCT;
  logic       carry_out;

  int vectors;
  int errors;
  logic [8:0] exp_q[$];

  multiplier_4bit_carry dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .carry_in  (carry_in),
    .PRODUCT   (PRODUCT),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs now; the result is expected after the next rising edge.
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [7:0] ep, input logic ec);
    A        = a;
    B        = b;
    carry_in = c;
    exp_q.push_back({ec, ep});
  endtask

  task automatic check_now(input string name, input logic [7:0] ep, input logic ec);
    vectors++;
    if (PRODUCT !== ep || carry_out !== ec) begin
      errors++;
      $display("FAIL %s: got PRODUCT=%h carry_out=%b, want PRODUCT=%h carry_out=%b",
               name, PRODUCT, carry_out, ep, ec);
    end
  endtask

  initial begin
    logic [8:0] e;
    int         r;
    logic [3:0] a;
    logic [3:0] b;
    logic       c;

    vectors  = 0;
    errors   = 0;
    rst_n    = 1'b0;
    A        = 4'h0;
    B        = 4'h0;
    carry_in = 1'b0;

    fork
      forever begin
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          vectors++;
          if ({carry_out, PRODUCT} !== e) begin
            errors++;
            $display("FAIL scoreboard: got PRODUCT=%h carry_out=%b, want PRODUCT=%h carry_out=%b",
                     PRODUCT, carry_out, e[7:0], e[8]);
          end
        end
      end
    join_none

    #3;
    check_now("reset_state", 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release captures the current inputs.
    drive(4'd2, 4'd1, 1'b0, 8'h02, 1'b0);

    @(negedge clk); drive(4'd3, 4'd2, 1'b0, 8'h06, 1'b0);
    @(negedge clk); drive(4'd1, 4'd7, 1'b1, 8'h08, 1'b0);
    @(negedge clk); drive(4'd3, 4'd3, 1'b0, 8'h09, 1'b0);

    @(negedge clk); drive(4'd0, 4'd9, 1'b1, 8'h01, 1'b0);
    @(negedge clk); drive(4'd5, 4'd3, 1'b1, 8'h10, 1'b1);
    @(negedge clk); drive(4'd9, 4'd0, 1'b0, 8'h00, 1'b0);
    @(negedge clk); drive(4'd15, 4'd15, 1'b1, 8'hE2, 1'b1);

    // Async reset mid-cycle while the output holds E2.
    @(posedge clk);
    #4;
    check_now("hold_e2_before_reset", 8'hE2, 1'b1);
    rst_n = 1'b0;
    #1;
    check_now("async_reset_immediate", 8'h00, 1'b0);
    @(posedge clk); #1;
    check_now("reset_hold_edge1", 8'h00, 1'b0);
    @(posedge clk); #1;
    check_now("reset_hold_edge2", 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'd4, 4'd4, 1'b1, 8'h11, 1'b1);

    // Inputs changed between edges must not reach the outputs.
    @(negedge clk); drive(4'd6, 4'd7, 1'b0, 8'h2A, 1'b1);
    @(posedge clk);
    #3;
    A        = 4'd1;
    B        = 4'd1;
    carry_in = 1'b0;
    #1;
    check_now("mid_cycle_change_ignored", 8'h2A, 1'b1);
    @(negedge clk); drive(4'd1, 4'd1, 1'b0, 8'h01, 1'b0);

    // Exhaustive sweep, one combination per cycle.
    for (int i = 0; i < 512; i++) begin
      a = 4'((i >> 5) & 15);
      b = 4'((i >> 1) & 15);
      c = 1'(i & 1);
      r = int'(a) * int'(b) + int'(c);
      @(negedge clk);
      drive(a, b, c, 8'(r), (r > 15));
    end

    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/multiplier_4bit_carry.md
MULTIPLIER_4BIT_CARRY -- requirements
Module: multiplier_4bit_carry

Interface
REQ-001 Parameters SHALL be none; widths are fixed at 4-bit operands and an 8-bit product.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 A  input  4  first multiplicand, unsigned.
REQ-005 B  input  4  second multiplicand, unsigned.
REQ-006 carry_in  input  1  addend injected into the product (value 0 or 1).
REQ-007 PRODUCT  output  8  registered result A*B + carry_in, unsigned.
REQ-008 carry_out  output  1  registered flag, 1 when the result does not fit in 4 bits.

Function
REQ-009 The result SHALL be R = A*B + carry_in, all operands unsigned, computed at full precision.
REQ-010 R SHALL never exceed 8'hE2 (15*15+1 = 226), so PRODUCT SHALL hold R exactly with no truncation or wrap.
REQ-011 carry_out SHALL equal 1 exactly when R > 15, i.e. PRODUCT[7:4] != 0; otherwise 0.
REQ-012 The datapath SHALL be an unsigned array multiplier: four AND-gated partial-product rows summed by ripple full-adder rows.
REQ-013 carry_in SHALL enter as the carry into bit 0 of the first adder row, not through a separate incrementer.
REQ-014 A, B and carry_in SHALL be sampled on every rising edge of clk; no enable or handshake exists.
REQ-015 PRODUCT and carry_out SHALL be driven only from flip-flops, with latency exactly 1 cycle.
REQ-016 Inputs present at rising edge N SHALL appear on the outputs immediately after edge N and hold until edge N+1.
REQ-017 Throughput SHALL be one result per cycle; back-to-back input changes every cycle SHALL each produce their own result.
REQ-018 Input changes between clock edges SHALL have no effect on the outputs until the next rising edge.
REQ-019 Boundary A=0 or B=0: PRODUCT SHALL be {7'b0, carry_in} and carry_out SHALL be 0.
REQ-020 Boundary A=B=4'hF with carry_in=1: PRODUCT SHALL be 8'hE2 and carry_out SHALL be 1.
REQ-021 Boundary A*B=15 with carry_in=1: PRODUCT SHALL be 8'h10 and carry_out SHALL be 1, since the carry pushes R over 4 bits.
REQ-022 The design SHALL contain no latches and no combinational path from any input to any output.

Reset
REQ-023 Assertion of rst_n=0 SHALL immediately clear PRODUCT to 8'h00 and carry_out to 0, without waiting for a clock edge.
REQ-024 While rst_n=0 the outputs SHALL hold at zero regardless of clock or inputs.
REQ-025 The first rising edge after deassertion (rst_n=1) SHALL capture the current inputs normally.
REQ-026 Reset asserted mid-stream SHALL discard the pending result, with no residual state after reset is released.

Verification
REQ-027 The bench SHALL cover A=2, B=1, carry_in=0 -> after the next edge, PRODUCT=8'h02 and carry_out=0.
REQ-028 The bench SHALL cover a per-cycle input sequence (3,2,0), (1,7,1), (3,3,0) -> PRODUCT=8'h06, then 8'h08 with carry_out=0, then 8'h09 with carry_out=0, one cycle after each input.
REQ-029 The bench SHALL cover the extremes: (15,15,1) -> 8'hE2 with carry_out=1; (0,9,1) -> 8'h01 with carry_out=0; (5,3,1) -> 8'h10 with carry_out=1.
REQ-030 The bench SHALL run an exhaustive sweep of all 512 (A,B,carry_in) combinations, one per cycle, each compared one cycle later against A*B+carry_in and the R>15 rule.
REQ-031 The bench SHALL assert rst_n=0 asynchronously mid-cycle while PRODUCT=8'hE2 -> outputs go to zero at once and stay zero through the clock edges; after release, the next edge yields the new result.
REQ-032 The bench SHALL change inputs between edges -> the outputs stay unchanged until the following rising edge.
